fir_tap_window: RTL

Sample-stream front end for the 6-tap FIR datapath. Accepts one sample per valid/ready handshake, keeps a 6-deep delay line, and presents the window as six parallel tap buses wired straight to the FIR multiplier inputs (tap_1..tap_6 drive in_1_0..in_6_0). After each window update it holds the taps stable for a programmable settle time, so the combinational multiplier/adder tree, including approximate variants, can resolve. It then pulses tap_valid so the downstream stage can capture the filter output.

---
 rtl/fir_tap_window.sv | 102 ++++++++++
 1 files changed

// File: rtl/fir_tap_window.sv
// Sample-stream front end for the 6-tap FIR: a 6-deep delay line whose taps are held
// stable for SETTLE cycles after every window update before tap_valid strobes.
module fir_tap_window #(
    parameter int DATA_W    = 16,
    parameter int SETTLE    = 2,
    parameter int ZERO_FILL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              flush,
    output logic [DATA_W-1:0] tap_1,
    output logic [DATA_W-1:0] tap_2,
    output logic [DATA_W-1:0] tap_3,
    output logic [DATA_W-1:0] tap_4,
    output logic [DATA_W-1:0] tap_5,
    output logic [DATA_W-1:0] tap_6,
    output logic              tap_valid,
    output logic [15:0]       win_cnt,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    // Handshake: a sample is taken at a rising edge when s_valid && s_ready.
    // s_ready is decoded from state, flush and rst only, so it never depends on s_valid.

    localparam logic [1:0] ST_FILL    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;
    localparam logic [1:0] ST_WAIT    = 2'd3;

    localparam logic [3:0] SETTLE_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    // A completed window skips SETTLE entirely when no settle time is programmed.
    localparam logic [1:0] ST_AFTER_WIN = (SETTLE == 0) ? ST_PRESENT : ST_SETTLE;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [3:0]        settle_cnt;
    logic [2:0]        fill;
    logic [2:0]        fill_next;
    logic [DATA_W-1:0] taps [6];
    logic              accept;

    assign s_ready   = !rst && !flush && (state != ST_SETTLE);
    assign accept    = s_valid && s_ready;
    assign tap_valid = (state == ST_PRESENT);
    assign busy      = (state == ST_SETTLE);
    assign state_dbg = state;
    assign fill_next = (fill == 3'd6) ? 3'd6 : fill + 3'd1;

    assign tap_1 = taps[0];
    assign tap_2 = taps[1];
    assign tap_3 = taps[2];
    assign tap_4 = taps[3];
    assign tap_5 = taps[4];
    assign tap_6 = taps[5];

    always_comb begin
        state_next = state;
        case (state)
            ST_FILL: begin
                if (accept && ((fill_next == 3'd6) || (ZERO_FILL != 0)))
                    state_next = ST_AFTER_WIN;
            end
            ST_SETTLE: begin
                if (settle_cnt == 4'd0)
                    state_next = ST_PRESENT;
            end
            default: begin
                state_next = accept ? ST_AFTER_WIN : ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state      <= ST_FILL;
            settle_cnt <= 4'd0;
            fill       <= 3'd0;
            win_cnt    <= 16'd0;
            for (int k = 0; k < 6; k++)
                taps[k] <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                taps[0] <= s_data;
                for (int k = 1; k < 6; k++)
                    taps[k] <= taps[k-1];
                fill <= fill_next;
            end
            if ((state != ST_SETTLE) && (state_next == ST_SETTLE))
                settle_cnt <= SETTLE_LOAD;
            else if ((state == ST_SETTLE) && (settle_cnt != 4'd0))
                settle_cnt <= settle_cnt - 4'd1;
            if (state == ST_PRESENT)
                win_cnt <= win_cnt + 16'd1;
        end
    end

endmodule
